main_memory_responder: RTL and testbench
========================================

Name: main_memory_responder

Overview:
- Memory-side responder for the cache controller FSM's MStrobe/MRW interface.
- Models a multi-cycle main memory with fixed access latency.
- Read transactions return a full cache line as a burst of consecutive words.
- Write transactions are single-word write-through.
- Sits directly below the cache controller. Its MRdy and MValid outputs drive the controller's counter load and ready-enable logic.

Parameters:
ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words
DATA_W, 32, word width in bits
LATENCY, 4, idle wait cycles between acceptance and first response; legal range 1..15
BURST, 4, words per cache line returned on a read; power of two, 2..16

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
MStrobe  input  1  request strobe; sampled only in IDLE
MRW  input  1  1 = read line, 0 = write word; sampled with MStrobe
MAddr  input  ADDR_W  word address; sampled with MStrobe
MDataIn  input  DATA_W  write data; sampled with MStrobe
MDataOut  output  DATA_W  read beat data; 0 when MValid=0
MValid  output  1  high for each read beat
MRdy  output  1  one-cycle pulse marking transaction completion
MBusy  output  1  high from the cycle after acceptance through the MRdy cycle

Behaviour:
- All outputs are registered.
- Reset (async, active-high):
  - state=IDLE, MDataOut=0, MValid=0, MRdy=0, MBusy=0, counters=0.
  - Memory array contents are not reset.
  - Reset mid-transaction aborts it immediately. No further beats, no MRdy. A pending write is discarded.
- States: IDLE, WAIT, RBURST, WDONE.
- IDLE:
  - If MStrobe=1 at rising edge T, latch op, address and data, load wait counter with LATENCY, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Occupies cycles T+1..T+LATENCY with MBusy=1 and the counter decrementing.
  - When the counter reaches 1, go to RBURST (read) or WDONE (write).
- Read burst:
  - Base address = latched MAddr with the low log2(BURST) bits cleared.
  - Beat k (k=0..BURST-1) is presented in cycle T+LATENCY+1+k with MValid=1 and MDataOut=mem[base+k].
  - Beats are back-to-back with no gaps.
  - MRdy=1 coincides with the last beat only.
  - The beat counter has width log2(BURST). The address never crosses the aligned line boundary.
- Write:
  - Single cycle T+LATENCY+1 in WDONE with MRdy=1 and MValid=0.
  - mem[latched MAddr] is updated at the end of that cycle.
- After the MRdy cycle the block returns to IDLE. MBusy=0 in the following cycle.
- MStrobe behaviour outside IDLE:
  - MStrobe asserted while MBusy=1 (including the MRdy cycle) is ignored and not queued.
  - The earliest next acceptance is the first IDLE cycle after MRdy.
  - MAddr, MDataIn and MRW changes during a transaction have no effect.
- Read-after-write to the same address returns the written data. The write is committed before IDLE is re-entered.
- Read latency: first data LATENCY+1 cycles after the accepting edge; MRdy at LATENCY+BURST.
- Write latency: MRdy LATENCY+1 cycles after the accepting edge.

Test Plan:
1. Reset defaults: assert reset asynchronously between edges -> all outputs 0 immediately; MStrobe during reset -> no MBusy after release.
2. Write then read: write 0xDEADBEEF to 0x12 (LATENCY=4) -> MRdy single pulse 5 cycles after acceptance, MValid stays 0. Then read 0x12 -> 4 beats at cycles +5..+8 from addresses 0x10..0x13, beat 2 = 0xDEADBEEF, MRdy only on beat 3.
3. Line alignment: preload 0x20..0x23 with 1,2,3,4; read MAddr=0x23 -> beats 1,2,3,4 in order, no access to 0x24.
4. Strobe while busy: issue a read, then pulse MStrobe with MRW=0 at cycles +2 and +8 (the MRdy cycle) -> both ignored, memory unchanged, exactly 4 beats.
5. Back-to-back: hold MStrobe=1 continuously with reads -> each acceptance occurs in the IDLE cycle following MRdy; period = LATENCY+BURST+1 cycles; MBusy low exactly one cycle between transactions.
6. Reset mid-burst: assert reset during beat 1 of a read -> MValid/MRdy drop to 0 at once, state IDLE, a new read after release returns a full correct 4-beat burst.

Source files
------------

// File: rtl/main_memory_responder.sv
// Main-memory model for the cache controller: fixed-latency single-word writes
// and line-aligned read bursts over the MStrobe/MRW handshake.
module main_memory_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4,
    parameter int BURST   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MValid,
    output logic              MRdy,
    output logic              MBusy
);

    localparam int BW = $clog2(BURST);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RBURST, ST_WDONE} state_t;

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic [BW-1:0]       beat_r, beat_s;
    logic                rw_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic [ADDR_W-1:0]   rd_addr_s;
    logic [DATA_W-1:0]   data_s;
    logic                valid_s, rdy_s, busy_s;

    // State, counters and the request latched at acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            beat_r  <= BW'(0);
            rw_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            beat_r  <= beat_s;
            if (state_r == ST_IDLE && MStrobe) begin
                rw_r    <= MRW;
                addr_r  <= MAddr;
                wdata_r <= MDataIn;
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        beat_s  = beat_r;
        case (state_r)
            ST_IDLE: begin
                if (MStrobe) begin
                    state_s = ST_WAIT;
                    cnt_s   = 4'(LATENCY);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_s = rw_r ? ST_RBURST : ST_WDONE;
                    cnt_s   = 4'd0;
                    beat_s  = BW'(0);
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RBURST: begin
                if (beat_r == BW'(BURST - 1)) begin
                    state_s = ST_IDLE;
                    beat_s  = BW'(0);
                end else begin
                    beat_s = beat_r + BW'(1);
                end
            end
            ST_WDONE: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle; the beat index wraps inside the aligned line
    always_comb begin
        rd_addr_s = {addr_r[ADDR_W-1:BW], beat_s};
        valid_s   = (state_s == ST_RBURST);
        data_s    = valid_s ? mem[rd_addr_s] : {DATA_W{1'b0}};
        rdy_s     = (state_s == ST_WDONE) || (valid_s && (beat_s == BW'(BURST - 1)));
        busy_s    = (state_s != ST_IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MDataOut <= {DATA_W{1'b0}};
            MValid   <= 1'b0;
            MRdy     <= 1'b0;
            MBusy    <= 1'b0;
        end else begin
            MDataOut <= data_s;
            MValid   <= valid_s;
            MRdy     <= rdy_s;
            MBusy    <= busy_s;
        end
    end

    // Write commits at the end of the WDONE cycle; reset forces IDLE so a pending write is dropped
    always_ff @(posedge clk) begin
        if (state_r == ST_WDONE) begin
            mem[addr_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: a transaction table checked cycle by
// cycle, plus hand-written reset, busy-strobe and back-to-back sequences.
module tb_main_memory_responder;

    localparam int LAT = 4;
    localparam int BUR = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MStrobe = 1'b0;
    logic        MRW = 1'b0;
    logic [7:0]  MAddr = 8'h00;
    logic [31:0] MDataIn = 32'h0;
    logic [31:0] MDataOut;
    logic        MValid, MRdy, MBusy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic             rw;
        logic [7:0]       addr;
        logic [31:0]      wdata;
        logic [3:0][31:0] line;
    } vec_t;

    vec_t vecs [19];
    logic [3:0][31:0] line20;

    main_memory_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(LAT), .BURST(BUR)) dut (
        .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
        .MDataIn(MDataIn), .MDataOut(MDataOut), .MValid(MValid), .MRdy(MRdy), .MBusy(MBusy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rw, input logic [7:0] a, input logic [31:0] d,
                                input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3);
        vec_t v;
        v.rw = rw; v.addr = a; v.wdata = d;
        v.line = {b3, b2, b1, b0};
        return v;
    endfunction

    task automatic chk(input string name, input int cyc, input logic [34:0] exp);
        logic [34:0] act;
        act = {MBusy, MValid, MRdy, MDataOut};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got busy/valid/rdy/data=%b%b%b/%h expected %b%b%b/%h",
                     name, cyc, act[34], act[33], act[32], act[31:0],
                     exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    // One transaction, checked in every cycle from acceptance+1 to the idle cycle after MRdy.
    // poke=1 fires ignored write strobes in cycle 2 and in the MRdy cycle.
    task automatic txn(input string name, input logic rw, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0][31:0] line, input bit poke);
        int total;
        logic v;
        @(negedge clk);
        MStrobe = 1'b1; MRW = rw; MAddr = a; MDataIn = d;
        @(posedge clk);
        #1;
        MStrobe = 1'b0; MRW = ~rw; MAddr = ~a; MDataIn = ~d;
        total = rw ? LAT + BUR : LAT + 1;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            v = rw && (c > LAT);
            chk(name, c, {1'b1, v, (c == total) ? 1'b1 : 1'b0, v ? line[c-LAT-1] : 32'h0});
            if (poke && (c == 2 || c == total)) begin
                MStrobe = 1'b1; MRW = 1'b0; MAddr = a; MDataIn = 32'h0BAD_0BAD;
            end else begin
                MStrobe = 1'b0;
            end
        end
        @(negedge clk);
        MStrobe = 1'b0;
        chk({name, "_idle"}, total + 1, 35'h0);
    endtask

    initial begin
        logic [31:0] dd;
        int m;
        line20 = {32'h4, 32'h33, 32'h2, 32'h1};
        vecs[0]  = mk(1'b0, 8'h10, 32'h1010_0000, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[1]  = mk(1'b0, 8'h11, 32'h1111_1111, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[2]  = mk(1'b0, 8'h13, 32'h1313_1313, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[3]  = mk(1'b0, 8'h12, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[4]  = mk(1'b1, 8'h12, 32'h0, 32'h1010_0000, 32'h1111_1111, 32'hDEAD_BEEF, 32'h1313_1313);
        vecs[5]  = mk(1'b0, 8'h20, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[6]  = mk(1'b0, 8'h21, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[7]  = mk(1'b0, 8'h22, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[8]  = mk(1'b0, 8'h23, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[9]  = mk(1'b0, 8'h24, 32'hAAAA_AAAA, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[10] = mk(1'b1, 8'h23, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4);
        vecs[11] = mk(1'b0, 8'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[12] = mk(1'b1, 8'h21, 32'h0, 32'h1, 32'h2, 32'h33, 32'h4);
        vecs[13] = mk(1'b0, 8'hFC, 32'hC0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[14] = mk(1'b0, 8'hFD, 32'hC1, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[15] = mk(1'b0, 8'hFE, 32'hC2, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[16] = mk(1'b0, 8'hFF, 32'hC3, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[17] = mk(1'b1, 8'hFF, 32'h0, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
        vecs[18] = mk(1'b1, 8'h10, 32'h0, 32'h1010_0000, 32'h1111_1111, 32'hDEAD_BEEF, 32'h1313_1313);

        // Asynchronous reset between edges, strobe held during reset
        #2 reset = 1'b1;
        #1 chk("reset_async", 0, 35'h0);
        MStrobe = 1'b1; MRW = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_held", 0, 35'h0);
        reset = 1'b0; MStrobe = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("reset_release", c, 35'h0);
        end

        for (int i = 0; i < 19; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].line, 1'b0);
        end

        // Strobes while busy (cycle 2 and MRdy cycle) are ignored; memory unchanged afterwards
        txn("busy_poke", 1'b1, 8'h20, 32'h0, line20, 1'b1);
        txn("after_poke", 1'b1, 8'h22, 32'h0, line20, 1'b0);

        // Back-to-back reads with MStrobe held: period LAT+BUR+1, one idle cycle between
        @(negedge clk);
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h21;
        @(posedge clk);
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            m = c % 9;
            dd = (m >= 5) ? line20[m-5] : 32'h0;
            chk("b2b", c, {(m != 0) ? 1'b1 : 1'b0, (m >= 5) ? 1'b1 : 1'b0,
                           (m == 8) ? 1'b1 : 1'b0, dd});
            if (c == 27) MStrobe = 1'b0;
        end
        @(negedge clk);
        chk("b2b_stop", 28, 35'h0);

        // Reset during beat 1 of a read
        @(negedge clk);
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h20;
        @(posedge clk);
        #1 MStrobe = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("rst_burst_pre", c, {1'b1, (c >= 5) ? 1'b1 : 1'b0, 1'b0,
                                     (c >= 5) ? line20[c-5] : 32'h0});
        end
        reset = 1'b1;
        #1 chk("rst_burst_async", 6, 35'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_burst_idle", 0, 35'h0);
        txn("rst_burst_reread", 1'b1, 8'h20, 32'h0, line20, 1'b0);

        // Reset during a pending write discards it
        @(negedge clk);
        MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h21; MDataIn = 32'h999;
        @(posedge clk);
        #1 MStrobe = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 chk("rst_write_async", 3, 35'h0);
        @(negedge clk);
        reset = 1'b0;
        txn("rst_write_check", 1'b1, 8'h21, 32'h0, line20, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
